mmio_switch: RTL

- Parametrised memory-mapped interconnect between the single CPU data/instruction bridge master and NUM_SLV peripheral/RAM slaves: RAM, UART, VGA number bank, keyboard, flash window.
- Generalises the fixed-target address decoding done today with a per-slave base/mask table.
- Adds a registered request/acknowledge handshake with variable slave wait states, an unmapped-address error response and an optional watchdog timeout.
- Master-side busy output drives the pipeline pause request.

---
 rtl/mmio_switch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mmio_switch.sv
// Memory-mapped interconnect: one CPU bridge master to NUM_SLV slaves via a base/mask
// decode table, registered req/ack handshake. Optional watchdog under MMIO_TIMEOUT_EN.
module mmio_switch #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int NUM_SLV = 4,
    // Slice i (bits [i*ADDR_W +: ADDR_W]) belongs to slave i; slave 0 is the RAM.
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {16'hBF20, 16'hBF10, 16'hBF00, 16'h0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {16'hFFF0, 16'hFFF0, 16'hFFF0, 16'h8000},
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m_req,
    input  logic                      m_we,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [DATA_W-1:0]         m_wdata,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_ack,
    output logic                      m_err,
    output logic                      busy,
    output logic [NUM_SLV-1:0]        s_req,
    output logic                      s_we,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]        s_ack,
    output logic [1:0]                state_dbg
);

    // Handshake: the master holds m_req and its payload until the one-cycle m_ack;
    // a slave sees s_req held until it returns s_ack for one cycle.
    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_SLV-1:0]   s_req_d;
    logic                 s_we_d;
    logic [ADDR_W-1:0]    s_addr_d;
    logic [DATA_W-1:0]    s_wdata_d;
    logic                 m_ack_d, m_err_d;
    logic [DATA_W-1:0]    m_rdata_d;
    logic                 hit;
    logic [SEL_W-1:0]     hit_idx;
    logic                 sel_ack;

`ifdef MMIO_TIMEOUT_EN
    logic [TO_W-1:0]      cnt_q, cnt_d;
`else
    logic                 unused_cfg;
    assign unused_cfg = ^{TIMEOUT[0], TO_W[0]};
`endif

    assign busy      = m_req & ~m_ack;
    assign state_dbg = state_q;
    assign sel_ack   = s_ack[sel_q];

    // Descending scan so the lowest-index match is the last assignment and wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        s_req_d   = s_req;
        s_we_d    = s_we;
        s_addr_d  = s_addr;
        s_wdata_d = s_wdata;
        m_ack_d   = 1'b0;
        m_err_d   = 1'b0;
        m_rdata_d = m_rdata;
`ifdef MMIO_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (m_req) begin
                    s_we_d    = m_we;
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    if (hit) begin
                        sel_d   = hit_idx;
                        s_req_d = NUM_SLV'(1) << hit_idx;
`ifdef MMIO_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                        state_d = ACCESS;
                    end else begin
                        m_ack_d   = 1'b1;
                        m_err_d   = 1'b1;
                        m_rdata_d = '0;
                        state_d   = RESP;
                    end
                end
            end
            ACCESS: begin
                if (sel_ack) begin
                    s_req_d   = '0;
                    m_ack_d   = 1'b1;
                    m_rdata_d = s_we ? '0 : s_rdata[sel_q*DATA_W +: DATA_W];
                    state_d   = RESP;
                end
`ifdef MMIO_TIMEOUT_EN
                else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    s_req_d   = '0;
                    m_ack_d   = 1'b1;
                    m_err_d   = 1'b1;
                    m_rdata_d = '0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            s_req   <= '0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            m_ack   <= 1'b0;
            m_err   <= 1'b0;
            m_rdata <= '0;
`ifdef MMIO_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            s_req   <= s_req_d;
            s_we    <= s_we_d;
            s_addr  <= s_addr_d;
            s_wdata <= s_wdata_d;
            m_ack   <= m_ack_d;
            m_err   <= m_err_d;
            m_rdata <= m_rdata_d;
`ifdef MMIO_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule
